// File: rtl/rx_pbm_pkg.sv
// Shared types for the RX packet-buffer write controller.
// State encoding, descriptor bundle and word/byte sizing helper.
package rx_pbm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DROP
  } state_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] len;
  } rx_desc_t;

  function automatic int bytes_per_word(input int dw);
    return dw / 8;
  endfunction

  localparam int BYTES_PER_WORD = bytes_per_word(32);

endpackage

// File: rtl/rx_desc_fifo.sv
// Descriptor FIFO with registered head output.
// A push into an empty FIFO is visible right after the pushing edge.
module rx_desc_fifo
  import rx_pbm_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  rx_desc_t din,
  input  logic     pop,
  output rx_desc_t dout,
  output logic     valid,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);

  rx_desc_t     mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW-1:0] rp_n;
  logic [AW:0]   cnt;
  logic [AW:0]   cnt_n;
  logic [AW:0]   left;
  logic          push_ok;
  logic          pop_ok;
  rx_desc_t      head_n;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && valid;
  assign rp_n    = rp + AW'(pop_ok);
  assign left    = cnt - (AW+1)'(pop_ok);
  assign cnt_n   = left + (AW+1)'(push_ok);

  always_comb begin
    head_n = mem[rp_n];
    if (left == '0) head_n = din;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wp] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      cnt   <= '0;
      valid <= 1'b0;
      dout  <= '0;
    end else begin
      if (push_ok) wp <= wp + 1'b1;
      rp    <= rp_n;
      cnt   <= cnt_n;
      valid <= (cnt_n != '0);
      dout  <= head_n;
    end
  end

endmodule

// File: rtl/rx_pbm_wr_ctrl.sv
// RX packet-buffer write controller: speculative ring writes, commit/rollback.
// Define RX_PBM_STATS_EN to build the packet/drop counters.
module rx_pbm_wr_ctrl
  import rx_pbm_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int DESC_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_wvalid,
  input  logic                  i_wlast,
  input  logic                  i_werror,
  output logic                  o_ready,
  input  logic [15:0]           i_meta_data,
  input  logic                  i_meta_valid,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_waddr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic [ADDR_WIDTH-1:0] o_desc_addr,
  output logic [15:0]           o_desc_len,
  output logic                  o_desc_valid,
  input  logic                  i_desc_ready,
  input  logic                  i_free_valid,
  input  logic [ADDR_WIDTH:0]   i_free_words,
  output logic [15:0]           o_pkt_cnt,
  output logic [15:0]           o_drop_cnt
);

  localparam int BPW = bytes_per_word(DATA_WIDTH);
  localparam logic [ADDR_WIDTH:0] RING = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t              state, state_n;
  logic [ADDR_WIDTH:0] wr_ptr, wr_ptr_n;
  logic [ADDR_WIDTH:0] start_ptr, start_n;
  logic [ADDR_WIDTH:0] free_ptr;
  logic [ADDR_WIDTH:0] wcnt, wcnt_n;
  logic [ADDR_WIDTH:0] used;
  logic                full;
  logic                acc;
  logic                wr_en;
  logic                last_chk;
  logic                push;
  logic                pkt_inc;
  logic                drop_inc;
  rx_desc_t            push_desc;
  rx_desc_t            fifo_dout;
  logic                fifo_full;
  logic                fifo_empty;
  logic                unused_hi;

  assign used    = wr_ptr - free_ptr;
  assign full    = (used == RING);
  assign acc     = i_wvalid && o_ready;

  always_comb begin
    state_n   = state;
    wr_ptr_n  = wr_ptr;
    start_n   = start_ptr;
    wcnt_n    = wcnt;
    wr_en     = 1'b0;
    last_chk  = 1'b0;
    push      = 1'b0;
    pkt_inc   = 1'b0;
    drop_inc  = 1'b0;
    push_desc = '0;
    unique case (state)
      IDLE: if (acc) begin
        start_n = wr_ptr;
        wcnt_n  = (ADDR_WIDTH+1)'(1);
        if (full) begin
          drop_inc = 1'b1;
          state_n  = i_wlast ? IDLE : DROP;
        end else begin
          wr_en    = 1'b1;
          wr_ptr_n = wr_ptr + 1'b1;
          last_chk = i_wlast;
          state_n  = WRITE;
        end
      end
      WRITE: if (acc) begin
        if (full) begin
          wr_ptr_n = start_ptr;
          drop_inc = 1'b1;
          state_n  = i_wlast ? IDLE : DROP;
        end else begin
          wr_en    = 1'b1;
          wr_ptr_n = wr_ptr + 1'b1;
          wcnt_n   = wcnt + 1'b1;
          last_chk = i_wlast;
        end
      end
      DROP: if (acc && i_wlast) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // Length is checked against the word count including this last beat
    if (last_chk) begin
      state_n = IDLE;
      if (!i_werror && i_meta_valid && !fifo_full &&
          {16'd0, i_meta_data} == 32'(wcnt_n) * 32'(BPW)) begin
        push      = 1'b1;
        pkt_inc   = 1'b1;
        push_desc = '{addr: 16'(start_n[ADDR_WIDTH-1:0]),
                      len:  i_meta_data};
      end else begin
        wr_ptr_n = start_n;
        drop_inc = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      start_ptr   <= '0;
      free_ptr    <= '0;
      wcnt        <= '0;
      o_ready     <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_waddr <= '0;
      o_mem_wdata <= '0;
    end else begin
      state     <= state_n;
      wr_ptr    <= wr_ptr_n;
      start_ptr <= start_n;
      wcnt      <= wcnt_n;
      o_ready   <= 1'b1;
      o_mem_we  <= wr_en;
      if (i_free_valid) free_ptr <= free_ptr + i_free_words;
      if (wr_en) begin
        o_mem_waddr <= wr_ptr[ADDR_WIDTH-1:0];
        o_mem_wdata <= i_wdata;
      end
    end
  end

  rx_desc_fifo #(.DEPTH(DESC_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (push_desc),
    .pop   (i_desc_ready),
    .dout  (fifo_dout),
    .valid (o_desc_valid),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign o_desc_addr = fifo_dout.addr[ADDR_WIDTH-1:0];
  assign o_desc_len  = fifo_dout.len;
  assign unused_hi   = ^{fifo_empty, fifo_dout.addr[15:ADDR_WIDTH]};

`ifdef RX_PBM_STATS_EN
  logic [15:0] pkt_cnt;
  logic [15:0] drop_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (pkt_inc && pkt_cnt != 16'hFFFF) pkt_cnt <= pkt_cnt + 1'b1;
      if (drop_inc && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  assign o_pkt_cnt  = pkt_cnt;
  assign o_drop_cnt = drop_cnt;
`else
  logic unused_stats;
  assign unused_stats = pkt_inc ^ drop_inc;
  assign o_pkt_cnt    = '0;
  assign o_drop_cnt   = '0;
`endif

endmodule
